// File: rtl/fsm_input_conditioner.sv
// fsm_input_conditioner
//   Conditions the raw asynchronous a/b inputs for the downstream a/b FSM.
//   Each channel has a multi-flop synchroniser followed by a 4-state,
//   counter-based glitch filter. The filter produces a registered clean level
//   and a registered one-cycle change strobe. The two channels are identical
//   and independent; per-channel state is held in 2-entry arrays, with
//   index 0 for channel a and index 1 for channel b.
module fsm_input_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_chg,
    output logic b_chg
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } filt_state_t;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             s;

    filt_state_t            state     [2];
    filt_state_t            state_nxt [2];
    logic [CNT_W-1:0]       cnt       [2];
    logic [CNT_W-1:0]       cnt_nxt   [2];
    logic [1:0]             lvl;
    logic [1:0]             lvl_nxt;
    logic [1:0]             chg;
    logic [1:0]             chg_nxt;

    // Synchroniser chains: raw enters bit 0, the settled sample leaves the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a_raw};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b_raw};
        end
    end

    assign s = {sync_b[SYNC_STAGES-1], sync_a[SYNC_STAGES-1]};

    // Filter state, stability counters, clean levels and change strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= LOW;
                cnt[i]   <= '0;
            end
            lvl <= '0;
            chg <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            lvl <= lvl_nxt;
            chg <= chg_nxt;
        end
    end

    // Next-state logic per channel. A new level is accepted only after
    // STABLE_CYCLES consecutive samples. Any earlier reversal returns to the
    // settled state with the counter cleared. The counter stops at
    // STABLE_CYCLES-1 because the commit happens on that compare.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
        end
        lvl_nxt = lvl;
        chg_nxt = '0;

        for (int i = 0; i < 2; i++) begin
            case (state[i])
                LOW: begin
                    if (s[i]) begin
                        state_nxt[i] = WAIT_HIGH;
                        cnt_nxt[i]   = CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!s[i]) begin
                        state_nxt[i] = LOW;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = HIGH;
                        cnt_nxt[i]   = '0;
                        lvl_nxt[i]   = 1'b1;
                        chg_nxt[i]   = 1'b1;
                    end else begin
                        cnt_nxt[i]   = cnt[i] + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s[i]) begin
                        state_nxt[i] = WAIT_LOW;
                        cnt_nxt[i]   = CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (s[i]) begin
                        state_nxt[i] = HIGH;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = LOW;
                        cnt_nxt[i]   = '0;
                        lvl_nxt[i]   = 1'b0;
                        chg_nxt[i]   = 1'b1;
                    end else begin
                        cnt_nxt[i]   = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt[i] = LOW;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    assign a     = lvl[0];
    assign b     = lvl[1];
    assign a_chg = chg[0];
    assign b_chg = chg[1];

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// tb_fsm_input_conditioner
//   Directed bench for fsm_input_conditioner with default parameters
//   (2 sync stages, 4 stable cycles, so a held level appears after 6 edges).
//   Inputs change on the falling edge. Outputs are sampled on the falling
//   edge and compared as {a, b, a_chg, b_chg}.
`timescale 1ns/1ps
module tb_fsm_input_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic a_chg;
    logic b_chg;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       ar;
        logic       br;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    fsm_input_conditioner #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .a_raw(a_raw),
        .b_raw(b_raw),
        .a    (a),
        .b    (b),
        .a_chg(a_chg),
        .b_chg(b_chg)
    );

    // 7 ns clock period
    always #3.5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {a, b, a_chg, b_chg};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {a,b,a_chg,b_chg}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rep(input int n, input logic ar, input logic br, input logic [3:0] exp);
        for (int k = 0; k < n; k++) tbl.push_back('{ar: ar, br: br, exp: exp});
    endtask

    initial begin
        // Build the per-cycle vector table. Row r is driven before edge r
        // and checked after edge r. It starts with both channels settled low.
        // Clean rise and fall on a
        rep(5, 1'b1, 1'b0, 4'b0000);
        rep(1, 1'b1, 1'b0, 4'b1010);
        rep(2, 1'b1, 1'b0, 4'b1000);
        rep(5, 1'b0, 1'b0, 4'b1000);
        rep(1, 1'b0, 1'b0, 4'b0010);
        rep(2, 1'b0, 1'b0, 4'b0000);
        // 3-clock pulse is rejected
        rep(3, 1'b1, 1'b0, 4'b0000);
        rep(5, 1'b0, 1'b0, 4'b0000);
        // 4-clock pulse passes as a 4-cycle pulse with two strobes
        rep(4, 1'b1, 1'b0, 4'b0000);
        rep(1, 1'b0, 1'b0, 4'b0000);
        rep(1, 1'b0, 1'b0, 4'b1010);
        rep(3, 1'b0, 1'b0, 4'b1000);
        rep(1, 1'b0, 1'b0, 4'b0010);
        rep(2, 1'b0, 1'b0, 4'b0000);
        // Simultaneous rise on a and b
        rep(5, 1'b1, 1'b1, 4'b0000);
        rep(1, 1'b1, 1'b1, 4'b1111);
        rep(2, 1'b1, 1'b1, 4'b1100);
        // b_raw toggles every clock: both channels hold
        for (int k = 0; k < 12; k++) rep(1, 1'b1, logic'(k % 2), 4'b1100);
        // Simultaneous fall
        rep(5, 1'b0, 1'b0, 4'b1100);
        rep(1, 1'b0, 1'b0, 4'b0011);
        rep(2, 1'b0, 1'b0, 4'b0000);

        // Test 1: reset held with raw inputs high, then release
        rst   = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("reset_hold", 4'b0000);
        end
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 6)       check("post_reset_wait", 4'b0000);
            else if (k == 6) check("post_reset_rise", 4'b1111);
            else             check("post_reset_hold", 4'b1100);
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (8) @(negedge clk);
        check("settle_low", 4'b0000);

        // Table-driven: clean steps, borderline pulses, simultaneous, independence
        foreach (tbl[r]) begin
            a_raw = tbl[r].ar;
            b_raw = tbl[r].br;
            @(negedge clk);
            check($sformatf("table_row_%0d", r + 1), tbl[r].exp);
        end

        // Test 3: glitch rejection while a is high
        a_raw = 1'b1;
        repeat (7) @(negedge clk);
        check("glitch_pre_high", 4'b1000);
        // 1 ns low pulse straddling the rising edge (reaches s for one cycle)
        #3 a_raw = 1'b0;
        #1 a_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("glitch_short", 4'b1000);
        end
        // Low for 3 clocks
        a_raw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("glitch_3clk_low", 4'b1000);
        end
        a_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("glitch_3clk_after", 4'b1000);
        end

        // Test 6: reset in the middle of a rising filter
        a_raw = 1'b0;
        repeat (8) @(negedge clk);
        check("midreset_pre_low", 4'b0000);
        a_raw = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1 check("midreset_asserted", 4'b0000);
        @(negedge clk);
        check("midreset_held", 4'b0000);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 6)       check("midreset_wait", 4'b0000);
            else if (k == 6) check("midreset_rise", 4'b1010);
            else             check("midreset_hold", 4'b1000);
        end

        // Asynchronous clear of high outputs, between clock edges
        b_raw = 1'b1;
        repeat (8) @(negedge clk);
        check("async_pre_high", 4'b1100);
        #1 rst = 1'b0;
        #1 check("async_clear", 4'b0000);
        @(negedge clk);
        check("async_clear_held", 4'b0000);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
